rs_entry_sched: RTL
===================

Name: rs_entry_sched

Overview:
- Reservation-station entry controller, one per RS.
- Allocation side: up to two free entries per cycle for dispatch. Entry A is the lowest free index; entry B is the highest free index.
- Issue side: one entry per cycle, chosen from busy and ready entries by a rotating-priority selector.
- Owns the busy vector and the round-robin pointer. Sits between the dispatch stage and the RS payload RAM / issue stage.

Parameters:
- ENTSEL, 3: width of an entry index.
- ENTNUM, 8: number of RS entries. Must equal 2**ENTSEL.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  clears all entries (branch mispredict).
- req_a  in  1  dispatch slot A requests an entry.
- req_b  in  1  dispatch slot B requests an entry.
- alloc_ok  out  1  every asserted request can be granted this cycle.
- alloc_ent_a  out  ENTSEL  entry for slot A.
- alloc_ent_b  out  ENTSEL  entry for slot B.
- ready_vec  in  ENTNUM  per-entry operands-ready flags from wakeup logic.
- issue_stall  in  1  issue stage cannot accept this cycle.
- issue_valid  out  1  an entry is selected for issue.
- issue_ent  out  ENTSEL  selected entry index.
- busy_vec  out  ENTNUM  registered busy bits.
- busy_cnt  out  ENTSEL+1  number of busy entries.

Behaviour:
- Reset: busy_vec=0, busy_cnt=0, rr_ptr=0. Outputs are combinational from these registers, so after reset alloc_ok=1 for any request pattern, issue_valid=0, and alloc_ent_a=0, alloc_ent_b=ENTNUM-1.
- free = ~busy_vec, taken from the registered value only. Entries freed this cycle are not allocatable until the next cycle.
- alloc_ent_a: lowest set bit of free. alloc_ent_b: highest set bit of free. When no bit is set, both are 0.
- Free count depends only on the free vector:
  - "one free" means exactly one free entry: en set and index_a == index_b.
  - "two free" means index_a != index_b (en implied).
- alloc_ok rules:
  - Neither request: alloc_ok=1.
  - Exactly one request: alloc_ok = (at least one free).
  - Both requests: alloc_ok = two free.
  - A lone req_b uses alloc_ent_b.
  - Allocation is all-or-nothing. When alloc_ok=0, no entry is allocated and dispatch stalls.
- Allocate event: a requesting slot with alloc_ok=1 sets its entry's busy bit at the next edge. Latency is 1 cycle; the entry is issue-eligible from the following cycle.
- Issue select:
  - cand = busy_vec & ready_vec.
  - Rotate cand right by rr_ptr, take the lowest set bit, then add rr_ptr modulo ENTNUM. The search order is rr_ptr, rr_ptr+1, ..., wrapping past ENTNUM-1 to 0.
  - issue_valid = |cand. It is combinational and holds regardless of issue_stall.
- Issue event: issue_valid & ~issue_stall. At the next edge it clears busy[issue_ent] and sets rr_ptr = issue_ent+1 (wraps to 0 at ENTNUM). With no issue event, rr_ptr holds.
- Simultaneous allocate and issue: allowed in the same cycle. The two are always distinct entries, since an allocated entry is free and an issued entry is busy.
- busy_cnt next value = busy_cnt + allocations (0..2) - issue event (0..1). It never exceeds ENTNUM and never goes negative.
- flush:
  - At the next edge: busy_vec=0 and busy_cnt=0. Overrides allocate and issue in the same cycle.
  - rr_ptr is unchanged.
  - Combinational outputs are not masked during flush; consumers ignore them.
- Reset has priority over flush. reset asserted mid-stream restores the reset state at the next edge.
- Full (busy_cnt=ENTNUM): alloc_ok=0 for any request. Empty: issue_valid=0.

Decomposition:
- Shared package: the ENTSEL/ENTNUM defaults for the RS and an index typedef sized by ENTSEL.
- Natural sub-modules:
  - Two priority-encoder instances, lowest-first and highest-first, for free-entry search.
  - One sub-module rr_select (rotate + lowest-first search + un-rotate) for the issue pick.
- Registers and the alloc/issue update logic live in the top.

Test Plan:
- Reset, then req_a=req_b=1 for 4 cycles with ready_vec=0:
  - Grants are (0,7), (1,6), (2,5), (3,4).
  - busy_cnt reaches 8; the 5th cycle gives alloc_ok=0.
- busy=8'b0111_1111, req_a=req_b=1 → alloc_ok=0 and no state change. Same state with only req_a=1 → alloc_ok=1, entry 7 allocated.
- All busy, ready_vec=8'hFF, issue_stall=0, rr_ptr=0 → issues 0,1,2,… in successive cycles. After entry 7 issues, rr_ptr wraps to 0.
- rr_ptr=5, cand=8'b0010_0100 → issue_ent=5. Next cycle, with cand=8'b0000_0100 → issue_ent=2. issue_stall=1 holds issue_ent, busy and rr_ptr unchanged.
- Same cycle: allocate (req_a=req_b=1) and issue entry 3 → busy_cnt increases by net +1, bit 3 cleared, two new bits set.
- flush asserted together with req_a and an issue event → next cycle busy_vec=0, busy_cnt=0, rr_ptr unchanged. reset asserted during traffic → all registers 0 at the next edge.

Source files
------------

// File: rtl/rs_entry_sched_pkg.sv
// Shared sizing for the reservation-station entry controller.
package rs_entry_sched_pkg;

   localparam int RS_ENTSEL = 3;
   localparam int RS_ENTNUM = 2 ** RS_ENTSEL;

   typedef logic [RS_ENTSEL-1:0] ent_idx_t;

endpackage

// File: rtl/rs_entry_sched_penc.sv
// Priority encoder over a one-hot-or-more vector; searches lowest-first or highest-first.
module rs_entry_sched_penc #(
   parameter int W          = 8,
   parameter int SEL        = 3,
   parameter bit HIGH_FIRST = 1'b0
) (
   input  logic [W-1:0]   vec,
   output logic           en,
   output logic [SEL-1:0] idx
);

   // Later matches overwrite earlier ones, so the scan runs toward the preferred end.
   always_comb begin
      en  = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (HIGH_FIRST) begin
            if (vec[i]) begin
               en  = 1'b1;
               idx = SEL'(i);
            end
         end else begin
            if (vec[W-1-i]) begin
               en  = 1'b1;
               idx = SEL'(W-1-i);
            end
         end
      end
   end

endmodule

// File: rtl/rs_entry_sched_rr_select.sv
// Rotating-priority pick: first set bit of cand at or after ptr, wrapping modulo N.
module rs_entry_sched_rr_select #(
   parameter int N   = 8,
   parameter int SEL = 3
) (
   input  logic [N-1:0]   cand,
   input  logic [SEL-1:0] ptr,
   output logic           valid,
   output logic [SEL-1:0] ent
);

   // Rotate, lowest-first search and un-rotate folded into one scan: SEL-bit
   // index arithmetic wraps modulo N, and the smallest offset is written last.
   always_comb begin
      valid = |cand;
      ent   = '0;
      for (int unsigned k = N; k > 0; k--) begin
         if (cand[ptr + SEL'(k-1)]) begin
            ent = ptr + SEL'(k-1);
         end
      end
   end

endmodule

// File: rtl/rs_entry_sched.sv
// Reservation-station entry controller: dual free-entry allocation, round-robin issue select.
module rs_entry_sched
   import rs_entry_sched_pkg::*;
#(
   parameter int ENTSEL = RS_ENTSEL,
   parameter int ENTNUM = RS_ENTNUM
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_a,
   input  logic              req_b,
   output logic              alloc_ok,
   output logic [ENTSEL-1:0] alloc_ent_a,
   output logic [ENTSEL-1:0] alloc_ent_b,
   input  logic [ENTNUM-1:0] ready_vec,
   input  logic              issue_stall,
   output logic              issue_valid,
   output logic [ENTSEL-1:0] issue_ent,
   output logic [ENTNUM-1:0] busy_vec,
   output logic [ENTSEL:0]   busy_cnt
);

   localparam int CW = ENTSEL + 1;

   logic [ENTNUM-1:0] busy_q, busy_d, free, cand, set_mask, clr_mask;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ENTSEL-1:0] rr_q, rr_d, idx_a, idx_b, sel;
   logic              en_a, en_b, two_free, grant_a, grant_b, sel_valid, issue_fire;

   assign free = ~busy_q;
   assign cand = busy_q & ready_vec;

   rs_entry_sched_penc #(.W(ENTNUM), .SEL(ENTSEL), .HIGH_FIRST(1'b0)) u_penc_lo (
      .vec (free),
      .en  (en_a),
      .idx (idx_a)
   );

   rs_entry_sched_penc #(.W(ENTNUM), .SEL(ENTSEL), .HIGH_FIRST(1'b1)) u_penc_hi (
      .vec (free),
      .en  (en_b),
      .idx (idx_b)
   );

   rs_entry_sched_rr_select #(.N(ENTNUM), .SEL(ENTSEL)) u_rr_select (
      .cand  (cand),
      .ptr   (rr_q),
      .valid (sel_valid),
      .ent   (sel)
   );

   // Two distinct free entries exist only when the low and high searches disagree.
   assign two_free = en_a & en_b & (idx_a != idx_b);

   always_comb begin
      alloc_ok = 1'b1;
      if (req_a && req_b) begin
         alloc_ok = two_free;
      end else if (req_a || req_b) begin
         alloc_ok = en_a;
      end
   end

   assign grant_a    = req_a & alloc_ok;
   assign grant_b    = req_b & alloc_ok;
   assign issue_fire = sel_valid & ~issue_stall;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (grant_a) set_mask[idx_a] = 1'b1;
      if (grant_b) set_mask[idx_b] = 1'b1;
      if (issue_fire) clr_mask[sel] = 1'b1;
      busy_d = (busy_q | set_mask) & ~clr_mask;
      cnt_d  = cnt_q + CW'(grant_a) + CW'(grant_b) - CW'(issue_fire);
      rr_d   = issue_fire ? sel + ENTSEL'(1) : rr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         rr_q   <= '0;
      end else if (flush) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rr_q   <= rr_d;
      end
   end

   assign alloc_ent_a = idx_a;
   assign alloc_ent_b = idx_b;
   assign issue_valid = sel_valid;
   assign issue_ent   = sel;
   assign busy_vec    = busy_q;
   assign busy_cnt    = cnt_q;

endmodule
